// File: rtl/spi_master_fsm.sv
// SPI master, mode 0, MSB first: a 16-bit command word then 16 data bits per request,
// one cs_n per slave, with a response pulse carrying captured read data.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// SETUP | cs_n asserted, sclk low, first command bit on mosi
// CMD   | shifting out the 16 command bits
// TURN  | sclk parked low while the slave fetches read data
// DATA  | 16 data bits, written from wdata or sampled from miso
// HOLD  | sclk low before releasing cs_n
// GAP   | all cs_n high, enforced idle time between frames
module spi_master_fsm #(
   parameter int NUM_SLAVES = 8,
   parameter int CLK_DIV    = 4,
   parameter int CS_SETUP   = 4,
   parameter int TURNAROUND = 8,
   parameter int CS_GAP     = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [2:0]            req_slave,
   input  logic [7:0]            req_addr,
   input  logic [15:0]           req_wdata,
   output logic                  rsp_valid,
   output logic [15:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic                  busy,
   output logic                  sclk,
   output logic                  mosi,
   input  logic                  miso,
   output logic [NUM_SLAVES-1:0] cs_n
);
   typedef enum logic [2:0] {IDLE, SETUP, CMD, TURN, DATA, HOLD, GAP} state_t;

   localparam logic [15:0] T_SETUP = 16'(CS_SETUP - 1);
   localparam logic [15:0] T_DIV   = 16'(CLK_DIV - 1);
   localparam logic [15:0] T_TURN  = 16'(TURNAROUND - 1);
   localparam logic [15:0] T_GAP   = 16'(CS_GAP - 1);
   localparam logic [3:0]  NUM_SL  = 4'(NUM_SLAVES);

   state_t                  state, state_n;
   logic [15:0]             timer, timer_n;
   logic [3:0]              bit_idx, bit_idx_n;
   logic [15:0]             tx, tx_n, rx, rx_n, wdata_q, wdata_n;
   logic                    write_q, write_n, err_q, err_n;
   logic                    sclk_n, mosi_n, rsp_valid_n, rsp_err_n;
   logic [15:0]             rsp_rdata_n;
   logic [NUM_SLAVES-1:0]   cs_n_n;
   logic [1:0]              miso_sync;
   logic                    miso_s;
   logic                    accept;
   logic [15:0]             cmd_word;

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign accept    = req_valid & req_ready;
   assign miso_s    = miso_sync[1];
   assign cmd_word  = {2'b00, req_slave, req_addr, 1'b0, ~req_write, 1'b0};

   always_comb begin
      state_n     = state;
      timer_n     = timer;
      bit_idx_n   = bit_idx;
      tx_n        = tx;
      rx_n        = rx;
      wdata_n     = wdata_q;
      write_n     = write_q;
      err_n       = err_q;
      sclk_n      = sclk;
      mosi_n      = mosi;
      cs_n_n      = cs_n;
      rsp_valid_n = 1'b0;
      rsp_rdata_n = rsp_rdata;
      rsp_err_n   = rsp_err;
      case (state)
         IDLE: if (accept) begin
            state_n = SETUP;
            timer_n = T_SETUP;
            tx_n    = cmd_word;
            mosi_n  = cmd_word[15];
            rx_n    = '0;
            write_n = req_write;
            wdata_n = req_wdata;
            err_n   = ({1'b0, req_slave} >= NUM_SL);
            for (int i = 0; i < NUM_SLAVES; i++) cs_n_n[i] = (req_slave != 3'(i));
         end
         SETUP: if (timer == 16'd0) begin
            state_n   = CMD;
            sclk_n    = 1'b1;
            timer_n   = T_DIV;
            bit_idx_n = 4'd15;
         end else timer_n = timer - 16'd1;
         CMD, DATA: begin
            if (timer != 16'd0) timer_n = timer - 16'd1;
            else if (sclk) begin
               // falling edge: sample miso (data phase) and present the next bit
               sclk_n  = 1'b0;
               timer_n = T_DIV;
               if (state == DATA) rx_n = {rx[14:0], miso_s};
               if (bit_idx != 4'd0) begin
                  mosi_n = tx[14];
                  tx_n   = {tx[14:0], 1'b0};
               end else if (state == CMD) mosi_n = write_q & wdata_q[15];
               else mosi_n = 1'b0;
            end else if (bit_idx != 4'd0) begin
               sclk_n    = 1'b1;
               timer_n   = T_DIV;
               bit_idx_n = bit_idx - 4'd1;
            end else if (state == CMD) begin
               state_n = TURN;
               timer_n = T_TURN;
            end else begin
               state_n = HOLD;
               timer_n = T_DIV;
            end
         end
         TURN: if (timer == 16'd0) begin
            state_n   = DATA;
            sclk_n    = 1'b1;
            timer_n   = T_DIV;
            bit_idx_n = 4'd15;
            tx_n      = write_q ? wdata_q : 16'h0000;
         end else timer_n = timer - 16'd1;
         HOLD: if (timer == 16'd0) begin
            state_n     = GAP;
            timer_n     = T_GAP;
            cs_n_n      = '1;
            mosi_n      = 1'b0;
            rsp_valid_n = 1'b1;
            rsp_rdata_n = write_q ? 16'h0000 : rx;
            rsp_err_n   = err_q;
         end else timer_n = timer - 16'd1;
         GAP: if (timer == 16'd0) state_n = IDLE;
              else timer_n = timer - 16'd1;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         timer     <= '0;
         bit_idx   <= '0;
         tx        <= '0;
         rx        <= '0;
         wdata_q   <= '0;
         write_q   <= 1'b0;
         err_q     <= 1'b0;
         sclk      <= 1'b0;
         mosi      <= 1'b0;
         cs_n      <= '1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         miso_sync <= '0;
      end else begin
         state     <= state_n;
         timer     <= timer_n;
         bit_idx   <= bit_idx_n;
         tx        <= tx_n;
         rx        <= rx_n;
         wdata_q   <= wdata_n;
         write_q   <= write_n;
         err_q     <= err_n;
         sclk      <= sclk_n;
         mosi      <= mosi_n;
         cs_n      <= cs_n_n;
         rsp_valid <= rsp_valid_n;
         rsp_rdata <= rsp_rdata_n;
         rsp_err   <= rsp_err_n;
         miso_sync <= {miso_sync[0], miso};
      end
   end
endmodule

// File: tb/tb_spi_master_fsm.sv
// Bench for spi_master_fsm: behavioural RAM slaves on cs_n, directed transactions,
// frame/latency/chip-select checks against hand-computed values.
module tb_spi_master_fsm;
   localparam int NS = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0, req_write = 1'b0;
   logic [2:0]    req_slave = '0;
   logic [7:0]    req_addr = '0;
   logic [15:0]   req_wdata = '0;
   logic          req_ready, rsp_valid, rsp_err, busy, sclk, mosi, miso;
   logic [15:0]   rsp_rdata;
   logic [NS-1:0] cs_n;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spi_master_fsm #(.NUM_SLAVES(NS)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_slave(req_slave), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso),
      .cs_n(cs_n)
   );

   // slave RAM model: mode 0, 16-bit command then 16 data bits
   logic [15:0] ram [0:NS-1][0:255];
   int          s_cnt = 0;
   logic [15:0] s_cmd = '0, s_data = '0, s_out = '0;
   int          sel;
   logic        cs_idle;

   assign cs_idle = &cs_n;
   assign miso    = s_out[15];

   always_comb begin
      sel = -1;
      for (int i = 0; i < NS; i++) if (cs_n[i] === 1'b0) sel = i;
   end

   always @(sclk or cs_idle) begin
      if (cs_idle) s_cnt = 0;
      else if (sclk === 1'b1) begin
         if (s_cnt < 16) s_cmd = {s_cmd[14:0], mosi};
         else            s_data = {s_data[14:0], mosi};
         s_cnt++;
         if (s_cnt == 16 && s_cmd[1])  s_out = ram[sel][s_cmd[10:3]];
         if (s_cnt == 32 && !s_cmd[1]) ram[sel][s_cmd[10:3]] = s_data;
      end else if (s_cnt > 16) s_out = {s_out[14:0], 1'b0};
   end

   logic [31:0] frame = '0;
   int          rise_cnt = 0;
   always @(posedge sclk) begin
      frame = {frame[30:0], mosi};
      rise_cnt++;
   end

   int cs_low_cnt = 0, overlap_cnt = 0, rsp_cnt = 0;
   always @(negedge clk) begin
      if (cs_n !== '1) cs_low_cnt++;
      if ($countones(~cs_n) > 1) overlap_cnt++;
      if (rsp_valid === 1'b1) rsp_cnt++;
   end

   task automatic run_txn(input logic wr, input logic [2:0] sl, input logic [7:0] ad,
                          input logic [15:0] wd, output logic [15:0] rd, output logic er,
                          output int lat);
      int n = 0;
      @(negedge clk);
      while (req_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
      req_valid = 1'b1; req_write = wr; req_slave = sl; req_addr = ad; req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 2000) begin @(negedge clk); lat++; end
      rd = rsp_rdata;
      er = rsp_err;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (cs_n !== 2'b11) begin errors++; $display("FAIL reset_cs_n: got %b expected 11", cs_n); end
      checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
      checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
      checks++; if (rsp_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rsp_rdata: got %h expected 0000", rsp_rdata); end
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
   endtask

   task automatic test_write();
      logic [15:0] rd; logic er; int lat; int r0;
      r0 = rise_cnt;
      run_txn(1'b1, 3'd0, 8'h12, 16'hA5C3, rd, er, lat);
      checks++; if (lat !== 273) begin errors++; $display("FAIL write_latency: got %0d expected 273", lat); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL write_err: got %b expected 0", er); end
      checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL write_rdata: got %h expected 0000", rd); end
      checks++; if (frame !== 32'h0090A5C3) begin errors++; $display("FAIL write_frame: got %h expected 0090a5c3", frame); end
      checks++; if (rise_cnt - r0 !== 32) begin errors++; $display("FAIL write_rises: got %0d expected 32", rise_cnt - r0); end
      checks++; if (ram[0][8'h12] !== 16'hA5C3) begin errors++; $display("FAIL write_ram: got %h expected a5c3", ram[0][8'h12]); end
   endtask

   task automatic test_read();
      logic [15:0] rd; logic er; int lat;
      run_txn(1'b0, 3'd0, 8'h12, 16'h0000, rd, er, lat);
      checks++; if (rd !== 16'hA5C3) begin errors++; $display("FAIL read_rdata: got %h expected a5c3", rd); end
      checks++; if (frame[31:16] !== 16'h0092) begin errors++; $display("FAIL read_cmd: got %h expected 0092", frame[31:16]); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL read_err: got %b expected 0", er); end
      checks++; if (lat !== 273) begin errors++; $display("FAIL read_latency: got %0d expected 273", lat); end
   endtask

   task automatic test_back_to_back();
      int n = 0, g = 0, lat;
      logic gap_ok = 1'b1;
      @(negedge clk);
      while (req_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
      req_valid = 1'b1; req_write = 1'b1; req_slave = 3'd0; req_addr = 8'h00; req_wdata = 16'h00FF;
      @(negedge clk);
      req_write = 1'b0; req_wdata = 16'h0000;
      n = 1;
      while (rsp_valid !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
      checks++; if (n !== 273) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 273", n); end
      while (req_ready !== 1'b1 && g < 2000) begin
         if (cs_n !== 2'b11) gap_ok = 1'b0;
         @(negedge clk); g++;
      end
      checks++; if (g !== 8) begin errors++; $display("FAIL b2b_gap_cycles: got %0d expected 8", g); end
      checks++; if (gap_ok !== 1'b1) begin errors++; $display("FAIL b2b_gap_cs_high: got %b expected 1", gap_ok); end
      checks++; if (ram[0][8'h00] !== 16'h00FF) begin errors++; $display("FAIL b2b_ram: got %h expected 00ff", ram[0][8'h00]); end
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 2000) begin @(negedge clk); lat++; end
      checks++; if (lat !== 273) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 273", lat); end
      checks++; if (rsp_rdata !== 16'h00FF) begin errors++; $display("FAIL b2b_read: got %h expected 00ff", rsp_rdata); end
   endtask

   task automatic test_invalid_slave();
      logic [15:0] rd; logic er; int lat; int r0, c0;
      r0 = rise_cnt; c0 = cs_low_cnt;
      run_txn(1'b0, 3'd7, 8'h05, 16'h0000, rd, er, lat);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL inval_err: got %b expected 1", er); end
      checks++; if (rise_cnt - r0 !== 32) begin errors++; $display("FAIL inval_rises: got %0d expected 32", rise_cnt - r0); end
      checks++; if (cs_low_cnt - c0 !== 0) begin errors++; $display("FAIL inval_cs_low_cycles: got %0d expected 0", cs_low_cnt - c0); end
      checks++; if (lat !== 273) begin errors++; $display("FAIL inval_latency: got %0d expected 273", lat); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] rd; logic er; int lat; int n = 0, r0, p0;
      run_txn(1'b1, 3'd0, 8'h34, 16'h1111, rd, er, lat);
      @(negedge clk);
      while (req_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
      r0 = rise_cnt; p0 = rsp_cnt;
      req_valid = 1'b1; req_write = 1'b1; req_slave = 3'd0; req_addr = 8'h34; req_wdata = 16'hBEEF;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (rise_cnt - r0 < 10 && n < 2000) begin @(negedge clk); n++; end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (cs_n !== 2'b11) begin errors++; $display("FAIL abort_cs_n: got %b expected 11", cs_n); end
      checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL abort_sclk: got %b expected 0", sclk); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
      repeat (300) @(negedge clk);
      checks++; if (rsp_cnt - p0 !== 0) begin errors++; $display("FAIL abort_rsp: got %0d expected 0", rsp_cnt - p0); end
      checks++; if (rise_cnt - r0 !== 10) begin errors++; $display("FAIL abort_rises: got %0d expected 10", rise_cnt - r0); end
      checks++; if (ram[0][8'h34] !== 16'h1111) begin errors++; $display("FAIL abort_ram: got %h expected 1111", ram[0][8'h34]); end
      run_txn(1'b0, 3'd0, 8'h34, 16'h0000, rd, er, lat);
      checks++; if (rd !== 16'h1111) begin errors++; $display("FAIL abort_readback: got %h expected 1111", rd); end
   endtask

   task automatic test_walking();
      logic [15:0] rd, d; logic er; int lat; logic [7:0] a; logic [2:0] sl; int o0;
      o0 = overlap_cnt;
      for (int i = 0; i < 8; i++) begin
         a  = 8'(1 << i);
         sl = 3'(i % 2);
         d  = ~{a, a};
         run_txn(1'b1, sl, a, d, rd, er, lat);
         run_txn(1'b0, sl, a, 16'h0000, rd, er, lat);
         checks++; if (rd !== d) begin errors++; $display("FAIL walk_read addr %h: got %h expected %h", a, rd, d); end
      end
      checks++; if (overlap_cnt - o0 !== 0) begin errors++; $display("FAIL walk_cs_overlap: got %0d expected 0", overlap_cnt - o0); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_invalid_slave();
      test_reset_mid();
      test_walking();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
